audio_player: RTL

Playback sample engine between the recording SRAM and the I2S block's DAC side. It fetches 16-bit signed samples from SRAM and applies fast (decimating) or slow (sample-repeating or interpolating) playback speed. Each output sample is presented on a valid/request handshake matched to the I2S playback port (`play_data`/`play_valid`/`request_play_data`). It runs on the system clock (`clk`, 12 MHz class), far faster than the 32 kHz sample rate.

---
 rtl/audio_player_pkg.sv | 31 +++
 rtl/audio_player_interp_div.sv | 69 ++++++
 rtl/audio_player.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_player_pkg.sv
// Shared types and constants for the playback engine.
// The playback engine's optional interpolation is enabled by AUDIO_PLAYER_INTERP_EN.
package audio_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 20;
    localparam int SPEED_MAX  = 8;

    // I2S top-level state encodings seen by the player's host.
    localparam logic [2:0] I2S_ST_PLAY   = 3'b010;
    localparam logic [2:0] I2S_ST_RECORD = 3'b110;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT_RD,
        ST_CALC,
        ST_PRESENT,
        ST_PAUSED
    } state_t;

    function automatic logic [3:0] clamp_speed(input logic [3:0] s);
        if (s == 4'd0)
            return 4'd1;
        else if (s > 4'(SPEED_MAX))
            return 4'(SPEED_MAX);
        else
            return s;
    endfunction

endpackage

// File: rtl/audio_player_interp_div.sv
// Restoring divider: DW-bit signed dividend by 4-bit unsigned divisor, DW+1 cycles
// from i_start to o_done. Quotient truncates toward zero; only the low QW bits are returned.
module interp_div #(
    parameter int DW = 21,
    parameter int QW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_start,
    input  logic [DW-1:0] i_dividend,
    input  logic [3:0]    i_divisor,
    output logic [QW-1:0] o_quot,
    output logic          o_done
);

    localparam int CW = $clog2(DW + 1);

    logic [DW-1:0] r_q;
    logic [3:0]    r_rem;
    logic [3:0]    r_div;
    logic          r_neg;
    logic          r_busy;
    logic [CW-1:0] r_cnt;

    logic [DW-1:0] w_mag;
    logic [4:0]    w_cat;
    logic          w_ge;
    logic [3:0]    w_sub;

    assign w_mag = i_dividend[DW-1] ? ({DW{1'b0}} - i_dividend) : i_dividend;
    assign w_cat = {r_rem, r_q[DW-1]};
    assign w_ge  = w_cat >= {1'b0, r_div};
    // Remainder stays below the divisor (at most 8), so 4 bits of the difference suffice.
    assign w_sub = w_cat[3:0] - r_div;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q    <= '0;
            r_rem  <= '0;
            r_div  <= '0;
            r_neg  <= 1'b0;
            r_busy <= 1'b0;
            r_cnt  <= '0;
            o_quot <= '0;
            o_done <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (i_start) begin
                r_busy <= 1'b1;
                r_cnt  <= '0;
                r_rem  <= '0;
                r_q    <= w_mag;
                r_neg  <= i_dividend[DW-1];
                r_div  <= i_divisor;
            end else if (r_busy) begin
                if (r_cnt != CW'(DW)) begin
                    r_rem <= w_ge ? w_sub : w_cat[3:0];
                    r_q   <= {r_q[DW-2:0], w_ge};
                    r_cnt <= r_cnt + 1'b1;
                end else begin
                    o_quot <= r_neg ? ({QW{1'b0}} - r_q[QW-1:0]) : r_q[QW-1:0];
                    o_done <= 1'b1;
                    r_busy <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/audio_player.sv
// Playback sample engine: SRAM fetch, fast/slow speed, valid/request output handshake.
// Define AUDIO_PLAYER_INTERP_EN for interpolated slow mode; otherwise slow mode holds samples.
module audio_player
    import audio_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              pause,
    input  logic              stop,
    input  logic              slow,
    input  logic [3:0]        speed,
    input  logic [ADDR_W-1:0] end_addr,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_rd,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic [DATA_W-1:0] play_data,
    output logic              play_valid,
    input  logic              request_play_data,
    output logic              busy,
    output logic              done
);

    // Wide address arithmetic so a+speed near the top cannot wrap back into range.
    localparam int AW = ADDR_W + 4;

    state_t            r_state;
    logic [AW-1:0]     r_a;
    logic [3:0]        r_k;
    logic [3:0]        r_speed;
    logic              r_slow;
    logic [ADDR_W-1:0] r_end;

    logic [AW-1:0]     w_end;
    logic [AW-1:0]     w_na;
    logic [AW-1:0]     w_a1;
    logic              w_k_more;

    assign w_end    = {4'b0000, r_end};
    assign w_na     = r_a + (r_slow ? AW'(1) : AW'(r_speed));
    assign w_a1     = r_a + AW'(1);
    assign w_k_more = (r_k + 4'd1) < r_speed;
    assign busy     = (r_state != ST_IDLE);

`ifdef AUDIO_PLAYER_INTERP_EN
    localparam int PW = DATA_W + 5;

    logic [DATA_W-1:0] r_prev;
    logic [DATA_W-1:0] r_cur;
    logic              r_phase;
    logic              r_last;
    logic              r_cstep;
    logic              r_div_start;

    logic [DATA_W:0]   w_diff;
    logic [PW-1:0]     w_prod;
    logic [DATA_W-1:0] w_quot;
    logic              w_div_done;
    logic [AW-1:0]     w_a2;

    assign w_diff = {r_cur[DATA_W-1], r_cur} - {r_prev[DATA_W-1], r_prev};
    // Modular multiply gives the correct two's complement low bits of the signed product.
    assign w_prod = {{4{w_diff[DATA_W]}}, w_diff} * {{(PW-4){1'b0}}, r_k};
    assign w_a2   = r_a + AW'(2);

    interp_div #(.DW(PW), .QW(DATA_W)) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (r_div_start),
        .i_dividend (w_prod),
        .i_divisor  (r_speed),
        .o_quot     (w_quot),
        .o_done     (w_div_done)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_a        <= '0;
            r_k        <= '0;
            r_speed    <= '0;
            r_slow     <= 1'b0;
            r_end      <= '0;
            sram_addr  <= '0;
            sram_rd    <= 1'b0;
            play_data  <= '0;
            play_valid <= 1'b0;
            done       <= 1'b0;
`ifdef AUDIO_PLAYER_INTERP_EN
            r_prev      <= '0;
            r_cur       <= '0;
            r_phase     <= 1'b0;
            r_last      <= 1'b0;
            r_cstep     <= 1'b0;
            r_div_start <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef AUDIO_PLAYER_INTERP_EN
            r_div_start <= 1'b0;
`endif
            if (stop) begin
                r_state    <= ST_IDLE;
                play_valid <= 1'b0;
                sram_rd    <= 1'b0;
            end else if (pause) begin
                if (r_state != ST_IDLE) begin
                    r_state    <= ST_PAUSED;
                    play_valid <= 1'b0;
                    sram_rd    <= 1'b0;
                end
            end else begin
                case (r_state)
                    ST_IDLE: if (start) begin
                        r_slow    <= slow;
                        r_speed   <= clamp_speed(speed);
                        r_end     <= end_addr;
                        r_a       <= '0;
                        r_k       <= '0;
                        sram_rd   <= 1'b1;
                        sram_addr <= '0;
                        r_state   <= ST_FETCH;
`ifdef AUDIO_PLAYER_INTERP_EN
                        r_phase   <= 1'b0;
                        r_last    <= 1'b0;
`endif
                    end
                    ST_PAUSED: if (start) begin
                        sram_rd   <= 1'b1;
                        sram_addr <= r_a[ADDR_W-1:0];
                        r_state   <= ST_FETCH;
`ifdef AUDIO_PLAYER_INTERP_EN
                        r_phase   <= 1'b0;
`endif
                    end
                    ST_FETCH: begin
                        sram_rd <= 1'b0;
                        r_state <= ST_WAIT_RD;
                    end
                    ST_WAIT_RD: begin
`ifdef AUDIO_PLAYER_INTERP_EN
                        if (r_slow) begin
                            if (!r_phase) begin
                                r_prev <= sram_rdata;
                                if (w_a1 > w_end) begin
                                    r_last     <= 1'b1;
                                    play_data  <= sram_rdata;
                                    play_valid <= 1'b1;
                                    r_state    <= ST_PRESENT;
                                end else begin
                                    r_last    <= 1'b0;
                                    r_phase   <= 1'b1;
                                    sram_rd   <= 1'b1;
                                    sram_addr <= w_a1[ADDR_W-1:0];
                                    r_state   <= ST_FETCH;
                                end
                            end else begin
                                r_cur       <= sram_rdata;
                                r_phase     <= 1'b0;
                                r_cstep     <= 1'b1;
                                r_div_start <= 1'b1;
                                r_state     <= ST_CALC;
                            end
                        end else
`endif
                        begin
                            play_data  <= sram_rdata;
                            play_valid <= 1'b1;
                            r_state    <= ST_PRESENT;
                        end
                    end
                    ST_PRESENT: if (request_play_data && play_valid) begin
                        play_valid <= 1'b0;
                        r_state    <= ST_CALC;
`ifdef AUDIO_PLAYER_INTERP_EN
                        r_cstep    <= 1'b0;
`endif
                    end
                    ST_CALC: begin
`ifdef AUDIO_PLAYER_INTERP_EN
                        if (r_slow) begin
                            if (r_cstep) begin
                                // Ignore a stale done from a run abandoned by pause.
                                if (w_div_done && !r_div_start) begin
                                    play_data  <= r_prev + w_quot;
                                    play_valid <= 1'b1;
                                    r_state    <= ST_PRESENT;
                                end
                            end else if (r_last) begin
                                done    <= 1'b1;
                                r_state <= ST_IDLE;
                            end else if (w_k_more) begin
                                r_k         <= r_k + 4'd1;
                                r_cstep     <= 1'b1;
                                r_div_start <= 1'b1;
                            end else begin
                                r_k    <= '0;
                                r_prev <= r_cur;
                                r_a    <= w_a1;
                                if (w_a2 > w_end) begin
                                    r_last     <= 1'b1;
                                    play_data  <= r_cur;
                                    play_valid <= 1'b1;
                                    r_state    <= ST_PRESENT;
                                end else begin
                                    r_phase   <= 1'b1;
                                    sram_rd   <= 1'b1;
                                    sram_addr <= w_a2[ADDR_W-1:0];
                                    r_state   <= ST_FETCH;
                                end
                            end
                        end else
`endif
                        begin
                            if (r_slow && w_k_more) begin
                                r_k        <= r_k + 4'd1;
                                play_valid <= 1'b1;
                                r_state    <= ST_PRESENT;
                            end else begin
                                r_k <= '0;
                                if (w_na > w_end) begin
                                    done    <= 1'b1;
                                    r_state <= ST_IDLE;
                                end else begin
                                    r_a       <= w_na;
                                    sram_rd   <= 1'b1;
                                    sram_addr <= w_na[ADDR_W-1:0];
                                    r_state   <= ST_FETCH;
                                end
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
